// File: rtl/lh_msg_framer.sv
// Message framer ahead of the light_hash core: buffers one host message, validates it,
// and replays it as HEAD/body/TAIL. Define LH_FRAMER_STATS_EN to add frame counters.
module lh_msg_framer #(
  parameter int         MAX_LEN   = 32,
  parameter logic [7:0] HEAD_BYTE = 8'hFF,
  parameter logic [7:0] TAIL_BYTE = 8'h00
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  in_byte,
  input  logic        in_valid,
  input  logic        in_last,
  output logic        in_ready,
  output logic [7:0]  message_byte,
  output logic        message_valid,
  input  logic        out_ready,
  output logic        err_invalid_message,
  output logic        frame_done
`ifdef LH_FRAMER_STATS_EN
  ,
  output logic [15:0] frames_sent,
  output logic [15:0] frames_dropped
`endif
);

  localparam int CW = $clog2(MAX_LEN + 1);
  localparam int IW = $clog2(MAX_LEN);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_COLLECT = 3'd1,
    ST_HEAD    = 3'd2,
    ST_BODY    = 3'd3,
    ST_TAIL    = 3'd4
  } state_e;

  state_e         state_q, state_d;
  logic [CW-1:0]  count_q, count_d;
  logic [IW-1:0]  idx_q, idx_d;
  logic           flag_q, flag_d;
  logic [7:0]     byte_q, byte_d;
  logic           valid_q, valid_d;
  logic           ready_q, ready_d;
  logic           err_q, err_d;
  logic           done_q, done_d;
  logic [7:0]     buffer_q [MAX_LEN];

  logic           host_xfer;
  logic           down_xfer;
  logic           bad_byte;
  logic           overflow;
  logic           buf_we;
  logic           last_body;

  assign host_xfer = in_valid & ready_q;
  assign down_xfer = valid_q & out_ready;
  assign bad_byte  = (in_byte < 8'h20) || (in_byte > 8'h7E);
  assign overflow  = (count_q == CW'(MAX_LEN));
  assign last_body = (CW'(idx_q) == (count_q - CW'(1)));

  // Next-state, counters and the registered-output image of the next cycle
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    idx_d   = idx_q;
    flag_d  = flag_q;
    err_d   = 1'b0;
    done_d  = 1'b0;
    buf_we  = 1'b0;
    byte_d  = byte_q;

    unique case (state_q)
      ST_IDLE: begin
        state_d = ST_COLLECT;
      end
      ST_COLLECT: begin
        if (host_xfer) begin
          if (!overflow) begin
            buf_we  = 1'b1;
            count_d = count_q + CW'(1);
          end else begin
            count_d = count_q;
          end
          flag_d = flag_q | bad_byte | overflow;
          if (in_last) begin
            if (flag_d) begin
              err_d   = 1'b1;
              flag_d  = 1'b0;
              count_d = {CW{1'b0}};
            end else begin
              state_d = ST_HEAD;
            end
          end else begin
            state_d = ST_COLLECT;
          end
        end else begin
          state_d = ST_COLLECT;
        end
      end
      ST_HEAD: begin
        if (down_xfer) begin
          state_d = ST_BODY;
          idx_d   = {IW{1'b0}};
        end else begin
          state_d = ST_HEAD;
        end
      end
      ST_BODY: begin
        if (down_xfer) begin
          if (last_body) begin
            state_d = ST_TAIL;
          end else begin
            idx_d = idx_q + IW'(1);
          end
        end else begin
          state_d = ST_BODY;
        end
      end
      ST_TAIL: begin
        if (down_xfer) begin
          state_d = ST_COLLECT;
          done_d  = 1'b1;
          count_d = {CW{1'b0}};
        end else begin
          state_d = ST_TAIL;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    ready_d = (state_d == ST_COLLECT);
    valid_d = (state_d == ST_HEAD) || (state_d == ST_BODY) || (state_d == ST_TAIL);

    // A stalled byte is re-selected unchanged because idx and buffer are frozen outside COLLECT
    case (state_d)
      ST_HEAD: byte_d = HEAD_BYTE;
      ST_BODY: byte_d = buffer_q[idx_d];
      ST_TAIL: byte_d = TAIL_BYTE;
      default: byte_d = byte_q;
    endcase
  end

  // Control state and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      count_q <= {CW{1'b0}};
      idx_q   <= {IW{1'b0}};
      flag_q  <= 1'b0;
      byte_q  <= 8'h00;
      valid_q <= 1'b0;
      ready_q <= 1'b0;
      err_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      idx_q   <= idx_d;
      flag_q  <= flag_d;
      byte_q  <= byte_d;
      valid_q <= valid_d;
      ready_q <= ready_d;
      err_q   <= err_d;
      done_q  <= done_d;
    end
  end

  // Message storage; stale contents are never replayed because count gates the body
  always_ff @(posedge clk) begin
    if (buf_we) begin
      buffer_q[count_q[IW-1:0]] <= in_byte;
    end
  end

  assign in_ready            = ready_q;
  assign message_byte        = byte_q;
  assign message_valid       = valid_q;
  assign err_invalid_message = err_q;
  assign frame_done          = done_q;

`ifdef LH_FRAMER_STATS_EN
  logic [15:0] sent_q;
  logic [15:0] dropped_q;

  // Wrap-around frame statistics, advanced alongside the pulses they count
  always_ff @(posedge clk) begin
    if (rst) begin
      sent_q    <= 16'd0;
      dropped_q <= 16'd0;
    end else begin
      if (done_d) begin
        sent_q <= sent_q + 16'd1;
      end
      if (err_d) begin
        dropped_q <= dropped_q + 16'd1;
      end
    end
  end

  assign frames_sent    = sent_q;
  assign frames_dropped = dropped_q;
`endif

endmodule

// File: tb/tb_lh_msg_framer.sv
// Scoreboard bench for lh_msg_framer: stimulus pushes expected downstream bytes and
// pulse markers into a queue; a negedge monitor pops and compares.
module tb_lh_msg_framer;

  localparam int EV_DONE = 256;
  localparam int EV_ERR  = 257;

  logic        clk;
  logic        rst;
  logic [7:0]  in_byte;
  logic        in_valid;
  logic        in_last;
  logic        in_ready;
  logic [7:0]  message_byte;
  logic        message_valid;
  logic        out_ready;
  logic        err_invalid_message;
  logic        frame_done;
`ifdef LH_FRAMER_STATS_EN
  logic [15:0] frames_sent;
  logic [15:0] frames_dropped;
`endif

  int          n_tests = 0;
  int          n_fail  = 0;
  int          exp_q[$];
  logic [7:0]  msg_q[$];
  bit          stall_mode = 1'b0;
  bit          hold_pend  = 1'b0;
  logic [7:0]  hold_byte  = 8'h00;

  lh_msg_framer dut (
    .clk                 (clk),
    .rst                 (rst),
    .in_byte             (in_byte),
    .in_valid            (in_valid),
    .in_last             (in_last),
    .in_ready            (in_ready),
    .message_byte        (message_byte),
    .message_valid       (message_valid),
    .out_ready           (out_ready),
    .err_invalid_message (err_invalid_message),
    .frame_done          (frame_done)
`ifdef LH_FRAMER_STATS_EN
    ,
    .frames_sent         (frames_sent),
    .frames_dropped      (frames_dropped)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Monitor: stream/pulse scoreboard, stall-hold and handshake exclusivity
  always @(negedge clk) begin
    if (message_valid && in_ready) begin
      check("ready_with_valid", 1, 0);
    end
    if (hold_pend) begin
      check("hold_valid", int'(message_valid), 1);
      check("hold_byte", int'(message_byte), int'(hold_byte));
    end
    hold_pend = message_valid && !out_ready && !rst;
    hold_byte = message_byte;
    if (message_valid && out_ready) begin
      if (exp_q.size() == 0) check("extra_byte", int'(message_byte), -1);
      else check("stream", int'(message_byte), exp_q.pop_front());
    end
    if (frame_done) begin
      if (exp_q.size() == 0) check("extra_frame_done", EV_DONE, -1);
      else check("frame_done_order", EV_DONE, exp_q.pop_front());
    end
    if (err_invalid_message) begin
      if (exp_q.size() == 0) check("extra_err", EV_ERR, -1);
      else check("err_order", EV_ERR, exp_q.pop_front());
    end
  end

  // Downstream stall pattern 1,0,0,1 while stall_mode is set
  initial begin
    int c = 0;
    forever begin
      @(posedge clk);
      #1;
      if (stall_mode) begin
        out_ready = ((c % 4) == 0) || ((c % 4) == 3);
        c++;
      end
    end
  end

  task automatic load_str(input string s);
    msg_q.delete();
    for (int i = 0; i < s.len(); i++) msg_q.push_back(s[i]);
  endtask

  task automatic load_rep(input logic [7:0] b, input int n);
    msg_q.delete();
    for (int i = 0; i < n; i++) msg_q.push_back(b);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic last);
    bit ok = 1'b0;
    in_valid = 1'b1;
    in_byte  = b;
    in_last  = last;
    for (int k = 0; k < 100; k++) begin
      if (in_ready) begin
        ok = 1'b1;
        break;
      end
      @(posedge clk);
      #1;
    end
    if (ok) begin
      @(posedge clk);
      #1;
    end else begin
      check("in_ready_timeout", 0, 1);
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  // mode: 0 = expectations pushed by caller, 1 = valid frame, 2 = dropped message
  task automatic send_msg(input int mode);
    if (mode == 1) begin
      exp_q.push_back(32'hFF);
      for (int i = 0; i < msg_q.size(); i++) exp_q.push_back(int'(msg_q[i]));
      exp_q.push_back(32'h00);
      exp_q.push_back(EV_DONE);
    end else if (mode == 2) begin
      exp_q.push_back(EV_ERR);
    end
    for (int i = 0; i < msg_q.size(); i++) send_byte(msg_q[i], (i == msg_q.size() - 1));
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 400; i++) begin
      if (exp_q.size() == 0) break;
      @(posedge clk);
      #1;
    end
    check("drain_pending", exp_q.size(), 0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    bit seen = 1'b0;
`ifdef LH_FRAMER_STATS_EN
    int exp_sent = 0;
    int exp_drop = 0;
`endif
    rst       = 1'b1;
    in_byte   = 8'h00;
    in_valid  = 1'b0;
    in_last   = 1'b0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready", int'(in_ready), 0);
    check("rst_msg_byte", int'(message_byte), 0);
    check("rst_msg_valid", int'(message_valid), 0);
    check("rst_err", int'(err_invalid_message), 0);
    check("rst_done", int'(frame_done), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("in_ready_after_rst", int'(in_ready), 1);

    load_str("abc");   send_msg(1); wait_drain();
    load_str("A\n");   send_msg(2); wait_drain();
    load_str("Z");     send_msg(1); wait_drain();
    load_rep(8'h41, 33); send_msg(2); wait_drain();
    load_rep(8'h41, 32); send_msg(1); wait_drain();

    stall_mode = 1'b1;
    load_str("hi");    send_msg(1); wait_drain();
    stall_mode = 1'b0;
    out_ready  = 1'b1;
    @(posedge clk);
    #1;

    exp_q.push_back(32'hFF);
    exp_q.push_back(32'h68);
    exp_q.push_back(32'h65);
    load_str("hello"); send_msg(0);
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (message_valid && out_ready && message_byte == 8'h65) begin
        seen = 1'b1;
        break;
      end
    end
    check("saw_0x65", int'(seen), 1);
    @(posedge clk);
    #1;
    rst       = 1'b1;
    out_ready = 1'b0;
    @(posedge clk);
    #1;
    check("rst_mid_valid", int'(message_valid), 0);
    check("rst_mid_done", int'(frame_done), 0);
    rst       = 1'b0;
    out_ready = 1'b1;
    check("rst_mid_pending", exp_q.size(), 0);
    repeat (2) @(posedge clk);
    #1;

    load_str("ok");    send_msg(1); wait_drain();
`ifdef LH_FRAMER_STATS_EN
    exp_sent = 1;
`endif
    load_str("xy");    send_msg(1); wait_drain();
    load_rep(8'h7F, 1); send_msg(2); wait_drain();
`ifdef LH_FRAMER_STATS_EN
    exp_sent = exp_sent + 1;
    exp_drop = exp_drop + 1;
    check("frames_sent", int'(frames_sent), exp_sent);
    check("frames_dropped", int'(frames_dropped), exp_drop);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    check("frames_sent_rst", int'(frames_sent), 0);
    check("frames_dropped_rst", int'(frames_dropped), 0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
